axis_adc_boxcar_decimator: RTL and testbench

Downstream consumer of the ADC AXI-Stream front end. Input beats carry two sign-extended 16-bit channels: A in bits [15:0], B in bits [31:16].
The block sums N consecutive accepted beats per channel (boxcar / integrate-and-dump) and emits one 64-bit beat per N inputs, each channel carried as a sign-extended 32-bit sum.
The input is never back-pressured, because the ADC source has no tready. If the output is stalled, completed sums are dropped and flagged.

---
 rtl/axis_adc_boxcar_decimator.sv | 170 +++++++++++++++++
 tb/tb_axis_adc_boxcar_decimator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_adc_boxcar_decimator.sv
`default_nettype none
// ============================================================================
//  Module   : axis_adc_boxcar_decimator
//  Purpose  : Boxcar (integrate-and-dump) decimator for a two-channel ADC
//             AXI-Stream. N consecutive accepted input beats are summed per
//             channel and one 64-bit result beat is emitted per block. The
//             input is never back-pressured; if the single-entry output
//             register is still occupied and stalled when a block completes,
//             the new sum is dropped and a sticky overrun flag is raised.
//  Ports    : aclk           - clock, all logic on the rising edge
//             aresetn        - asynchronous active-low reset
//             cfg_data       - decimation ratio N (unsigned, 0 = idle)
//             s_axis_tready  - input ready (registered, 1 after reset)
//             s_axis_tvalid  - input valid
//             s_axis_tdata   - {B, A} signed samples, AXIS_TDATA_WIDTH/2 each
//             m_axis_tready  - output ready
//             m_axis_tvalid  - output valid
//             m_axis_tdata   - {sumB[31:0], sumA[31:0]} two's complement
//             sts_overrun    - sticky, a completed sum was dropped
//  Revision : 1.0 - initial release
// ============================================================================
module axis_adc_boxcar_decimator #(
  parameter int AXIS_TDATA_WIDTH = 32,
  // AXIS_TDATA_WIDTH/2 + CNTR_WIDTH must not exceed 32 so that the 32-bit
  // accumulators can never overflow for the largest N.
  parameter int CNTR_WIDTH       = 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CNTR_WIDTH-1:0]       cfg_data,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tvalid,
  output logic [63:0]                 m_axis_tdata,
  output logic                        sts_overrun
);

  localparam int c_HALF_W = AXIS_TDATA_WIDTH / 2;
  localparam int c_ACC_W  = 32;
  localparam int c_EXT_W  = c_ACC_W - c_HALF_W;

  localparam logic [CNTR_WIDTH-1:0] c_CNT_ONE  = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNTR_WIDTH-1:0] c_CNT_ZERO = '0;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic                  r_s_tready;
  logic [CNTR_WIDTH-1:0] r_cfg;
  logic [CNTR_WIDTH-1:0] r_cnt;
  logic [c_ACC_W-1:0]    r_acc_a;
  logic [c_ACC_W-1:0]    r_acc_b;
  logic                  r_m_tvalid;
  logic [63:0]           r_m_tdata;
  logic                  r_overrun;

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic               w_beat;
  logic               w_cfg_change;
  logic               w_idle;
  logic               w_last;
  logic               w_complete;
  logic               w_xfer;
  logic               w_can_load;
  logic [c_ACC_W-1:0] w_sample_a;
  logic [c_ACC_W-1:0] w_sample_b;
  logic [c_ACC_W-1:0] w_sum_a;
  logic [c_ACC_W-1:0] w_sum_b;

  assign w_beat       = s_axis_tvalid & r_s_tready;
  assign w_cfg_change = (cfg_data != r_cfg);
  // When no change is detected cfg_data equals r_cfg, so r_cfg is the
  // effective ratio for every cycle that can accumulate.
  assign w_idle       = (r_cfg == c_CNT_ZERO);
  assign w_last       = (r_cnt == (r_cfg - c_CNT_ONE));

  // Sign extension of each channel to the accumulator width; plain unsigned
  // addition then gives correct two's complement sums.
  assign w_sample_a = {{c_EXT_W{s_axis_tdata[c_HALF_W-1]}},
                       s_axis_tdata[c_HALF_W-1:0]};
  assign w_sample_b = {{c_EXT_W{s_axis_tdata[AXIS_TDATA_WIDTH-1]}},
                       s_axis_tdata[AXIS_TDATA_WIDTH-1:c_HALF_W]};

  assign w_sum_a = r_acc_a + w_sample_a;
  assign w_sum_b = r_acc_b + w_sample_b;

  // A block completes only on a real accepted beat in a stable, non-idle
  // configuration; a beat landing in a change cycle is discarded.
  assign w_complete = w_beat & ~w_cfg_change & ~w_idle & w_last;

  assign w_xfer     = r_m_tvalid & m_axis_tready;
  // The output slot can take a new result if it is empty or being drained
  // in the same cycle (no bubble on back-to-back results).
  assign w_can_load = ~r_m_tvalid | m_axis_tready;

  // --------------------------------------------------------------------------
  // Input ready: low in reset, high from the first edge after release
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_s_tready <= 1'b0;
    end else begin
      r_s_tready <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Configuration tracking, block counter and accumulators
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cfg   <= c_CNT_ZERO;
      r_cnt   <= c_CNT_ZERO;
      r_acc_a <= '0;
      r_acc_b <= '0;
    end else begin
      r_cfg <= cfg_data;
      if (w_cfg_change || w_idle) begin
        // Restart from an empty block; accumulation resumes next cycle.
        r_cnt   <= c_CNT_ZERO;
        r_acc_a <= '0;
        r_acc_b <= '0;
      end else if (w_beat) begin
        if (w_last) begin
          r_cnt   <= c_CNT_ZERO;
          r_acc_a <= '0;
          r_acc_b <= '0;
        end else begin
          r_cnt   <= r_cnt + c_CNT_ONE;
          r_acc_a <= w_sum_a;
          r_acc_b <= w_sum_b;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Single-entry output register and sticky overrun flag
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_complete) begin
        if (w_can_load) begin
          r_m_tdata  <= {w_sum_b, w_sum_a};
          r_m_tvalid <= 1'b1;
        end else begin
          // Held beat is still stalled: keep it untouched, drop the new sum.
          r_overrun <= 1'b1;
        end
      end else if (w_xfer) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  assign s_axis_tready = r_s_tready;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = r_m_tdata;
  assign sts_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_axis_adc_boxcar_decimator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_adc_boxcar_decimator
//  Purpose  : Self-checking bench for axis_adc_boxcar_decimator. A queue-based
//             reference model collects accepted samples per block and sums
//             them when the block is full; directed and random stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_adc_boxcar_decimator;

  logic        aclk;
  logic        aresetn;
  logic [7:0]  cfg_data;
  logic        s_axis_tready;
  logic        s_axis_tvalid;
  logic [31:0] s_axis_tdata;
  logic        m_axis_tready;
  logic        m_axis_tvalid;
  logic [63:0] m_axis_tdata;
  logic        sts_overrun;

  int n_assert;
  int n_fail;

  // Reference model state
  int          q_a[$];
  int          q_b[$];
  logic [7:0]  m_cfg;
  bit          m_rdy;
  bit          m_vld;
  bit          m_ovr;
  logic [63:0] m_data;

  axis_adc_boxcar_decimator #(
    .AXIS_TDATA_WIDTH (32),
    .CNTR_WIDTH       (8)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_data      (cfg_data),
    .s_axis_tready (s_axis_tready),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .sts_overrun   (sts_overrun)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_a.delete();
    q_b.delete();
    m_cfg  = 8'd0;
    m_rdy  = 1'b0;
    m_vld  = 1'b0;
    m_ovr  = 1'b0;
    m_data = 64'd0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_tvalid"},  {63'd0, m_axis_tvalid}, {63'd0, m_vld});
    chk({tag, "_tdata"},   m_axis_tdata, m_data);
    chk({tag, "_overrun"}, {63'd0, sts_overrun}, {63'd0, m_ovr});
    chk({tag, "_tready"},  {63'd0, s_axis_tready}, {63'd0, m_rdy});
  endtask

  // One clock cycle: predict from the current inputs, clock, compare.
  task automatic step(input string tag);
    bit beat;
    bit done;
    int sa;
    int sb;
    beat = s_axis_tvalid && m_rdy;
    done = 1'b0;
    sa   = 0;
    sb   = 0;
    if (cfg_data != m_cfg || cfg_data == 8'd0) begin
      q_a.delete();
      q_b.delete();
    end else if (beat) begin
      q_a.push_back(int'($signed(s_axis_tdata[15:0])));
      q_b.push_back(int'($signed(s_axis_tdata[31:16])));
      if (q_a.size() == int'(cfg_data)) begin
        foreach (q_a[i]) sa += q_a[i];
        foreach (q_b[i]) sb += q_b[i];
        q_a.delete();
        q_b.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (!m_vld || m_axis_tready) begin
        m_data = {sb, sa};
        m_vld  = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_vld && m_axis_tready) begin
      m_vld = 1'b0;
    end
    m_cfg = cfg_data;
    m_rdy = 1'b1;
    @(posedge aclk);
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic v, input logic [15:0] a, input logic [15:0] b);
    s_axis_tvalid = v;
    s_axis_tdata  = {b, a};
  endtask

  // Called at posedge+1: reset is asserted between edges, so outputs must
  // clear without any clock edge.
  task automatic async_reset(input string tag);
    aresetn = 1'b0;
    #2;
    model_reset();
    check_all(tag);
    aresetn = 1'b1;
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    aresetn       = 1'b0;
    cfg_data      = 8'd0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 32'd0;
    m_axis_tready = 1'b1;
    model_reset();

    // Reset state
    #12;
    check_all("reset");
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    step("release");

    // 1: N=4, A=100, B=-3
    cfg_data = 8'd4;
    set_in(1'b1, 16'd100, 16'hFFFD);
    for (int i = 0; i < 20; i++) step("t1");
    chk("t1_sum", m_axis_tdata, 64'hFFFFFFF4_00000190);
    chk("t1_no_overrun", {63'd0, sts_overrun}, 64'd0);

    // 2: N=1, one output per input
    cfg_data = 8'd1;
    set_in(1'b1, 16'h8000, 16'h7FFF);
    for (int i = 0; i < 6; i++) step("t2");
    chk("t2_sum", m_axis_tdata, 64'h00007FFF_FFFF8000);
    chk("t2_valid", {63'd0, m_axis_tvalid}, 64'd1);

    // 3: N=255 extremes (one change cycle, then 255 beats per block)
    cfg_data = 8'd255;
    set_in(1'b1, 16'h8000, 16'h8000);
    for (int i = 0; i < 256; i++) step("t3n");
    chk("t3_neg", m_axis_tdata, 64'hFF808000_FF808000);
    set_in(1'b1, 16'h7FFF, 16'h7FFF);
    for (int i = 0; i < 255; i++) step("t3p");
    chk("t3_pos", m_axis_tdata, 64'h007F7F01_007F7F01);

    // 4: N=2 ramp with a 10-cycle output stall
    cfg_data = 8'd2;
    set_in(1'b0, 16'd0, 16'd0);
    step("t4_cfg");
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      set_in(1'b1, 16'(i), 16'd0);
      step("t4_stall");
      if (i >= 2) chk("t4_held", m_axis_tdata, 64'h00000000_00000003);
    end
    chk("t4_overrun", {63'd0, sts_overrun}, 64'd1);
    m_axis_tready = 1'b1;
    for (int i = 11; i <= 20; i++) begin
      set_in(1'b1, 16'(i), 16'd0);
      step("t4_run");
    end

    // 5: N=4, change to 2 after two accepted beats
    cfg_data = 8'd4;
    set_in(1'b0, 16'd0, 16'd0);
    step("t5_cfg4");
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 16'($urandom), 16'($urandom));
      step("t5_part");
    end
    cfg_data = 8'd2;
    set_in(1'b1, 16'($urandom), 16'($urandom));
    step("t5_change");
    chk("t5_no_valid_change", {63'd0, m_axis_tvalid}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 16'($urandom), 16'($urandom));
      step("t5_after");
    end

    // 6a: N=3 with random gaps and random output ready
    cfg_data = 8'd3;
    for (int i = 0; i < 60; i++) begin
      set_in(($urandom % 3) != 0, 16'($urandom), 16'($urandom));
      m_axis_tready = ($urandom % 4) != 0;
      step("t6_gap");
    end

    // 6b: N=0 idle
    m_axis_tready = 1'b1;
    cfg_data = 8'd0;
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 16'($urandom), 16'($urandom));
      step("t6_idle");
    end
    chk("t6_idle_valid", {63'd0, m_axis_tvalid}, 64'd0);

    // 6c: reset in the middle of a block
    cfg_data = 8'd5;
    for (int i = 0; i < 9; i++) begin
      set_in(1'b1, 16'($urandom), 16'($urandom));
      step("t6_preRst");
    end
    async_reset("t6_async_rst");
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 16'($urandom), 16'($urandom));
      step("t6_postRst");
    end

    // Random soak: occasional ratio changes, gaps, back-pressure
    for (int i = 0; i < 300; i++) begin
      if (($urandom % 20) == 0) cfg_data = 8'($urandom % 6);
      set_in(($urandom % 4) != 0, 16'($urandom), 16'($urandom));
      m_axis_tready = ($urandom % 3) != 0;
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
